// File: rtl/clusterv_mem_ctrl_pkg.sv
// Shared types for the clusterv banked SRAM controller: FSM states and bank index width.
package clusterv_mem_ctrl_pkg;

  localparam int BANK_IDX_W = 3;

  typedef logic [BANK_IDX_W-1:0] bank_idx_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ACK  = 3'd1,
    RD_WAIT = 3'd2,
    RD_ACK  = 3'd3,
    ERR_ACK = 3'd4
  } state_e;

  // True for the single-cycle response states that always fall back to IDLE.
  function automatic logic is_resp_state(input state_e st);
    return (st == WR_ACK) || (st == RD_ACK) || (st == ERR_ACK);
  endfunction

endpackage

// File: rtl/clusterv_mem_ctrl_bank_dec.sv
// Wishbone byte address -> (bank, word, in_range) decode.
// With CLUSTERV_MEMC_RANGE_ERR_EN out-of-range banks are flagged; otherwise the bank wraps modulo NUM_BANKS.
module clusterv_mem_ctrl_bank_dec
  import clusterv_mem_ctrl_pkg::*;
#(
  parameter int NUM_BANKS   = 4,
  parameter int BANK_ADDR_W = 9
) (
  input  logic [31:0]            t_adr,
  output bank_idx_t              bank,
  output logic [BANK_ADDR_W-1:0] word,
  output logic                   in_range
);

  localparam int BANK_LSB = 2 + BANK_ADDR_W;

  bank_idx_t bank_raw_s;
  logic      unused_adr_s;

  assign word         = t_adr[2 +: BANK_ADDR_W];
  assign bank_raw_s   = t_adr[BANK_LSB +: BANK_IDX_W];
  assign unused_adr_s = ^{t_adr[31:BANK_LSB+BANK_IDX_W], t_adr[1:0]};

`ifdef CLUSTERV_MEMC_RANGE_ERR_EN
  assign bank     = bank_raw_s;
  assign in_range = ({1'b0, bank_raw_s} < 4'(NUM_BANKS));
`else
  // Every bank index is legal once folded onto the populated banks.
  assign bank     = bank_idx_t'({1'b0, bank_raw_s} % 4'(NUM_BANKS));
  assign in_range = 1'b1;
`endif

endmodule

// File: rtl/clusterv_mem_ctrl_nbank.sv
// Wishbone slave fronting NUM_BANKS single-port SRAM macros: write ack in N+1, read ack in N+2.
// Optional CLUSTERV_MEMC_RANGE_ERR_EN turns accesses to unpopulated banks into t_err responses.
module clusterv_mem_ctrl_nbank
  import clusterv_mem_ctrl_pkg::*;
#(
  parameter int NUM_BANKS   = 4,
  parameter int BANK_ADDR_W = 9
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [31:0]             t_adr,
  input  logic [31:0]             t_dat_w,
  output logic [31:0]             t_dat_r,
  input  logic                    t_cyc,
  input  logic                    t_stb,
  input  logic                    t_we,
  input  logic [3:0]              t_sel,
  output logic                    t_ack,
  output logic                    t_err,
  output logic [NUM_BANKS-1:0]    sram_csb,
  output logic                    sram_web,
  output logic [3:0]              sram_wmask,
  output logic [BANK_ADDR_W-1:0]  sram_addr,
  output logic [31:0]             sram_din,
  input  logic [32*NUM_BANKS-1:0] sram_dout
);

  state_e                  state_q, state_d;
  bank_idx_t               rd_bank_q, rd_bank_d;
  logic                    ack_q, ack_d;
  logic [31:0]             dat_r_q, dat_r_d;

  bank_idx_t               dec_bank_s;
  logic [BANK_ADDR_W-1:0]  dec_word_s;
  logic                    dec_in_range_s;
  logic                    req_s;
  logic [NUM_BANKS-1:0]    bank_sel_s;
  logic [NUM_BANKS-1:0]    csb_s;
  logic                    web_s;
  logic [31:0]             rd_mux_s;

`ifdef CLUSTERV_MEMC_RANGE_ERR_EN
  logic                    err_q, err_d;
`endif

  clusterv_mem_ctrl_bank_dec #(
    .NUM_BANKS   (NUM_BANKS),
    .BANK_ADDR_W (BANK_ADDR_W)
  ) u_bank_dec (
    .t_adr    (t_adr),
    .bank     (dec_bank_s),
    .word     (dec_word_s),
    .in_range (dec_in_range_s)
  );

  // Gating with reset keeps every chip select high for the whole time reset is low.
  assign req_s = t_cyc & t_stb & reset;

  // One-hot bank select and AND-OR read-data mux on the captured read bank.
  always_comb begin
    bank_sel_s = {NUM_BANKS{1'b0}};
    rd_mux_s   = 32'd0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      bank_sel_s[k] = (dec_bank_s == bank_idx_t'(k));
      rd_mux_s      = rd_mux_s | ({32{rd_bank_q == bank_idx_t'(k)}} & sram_dout[32*k +: 32]);
    end
  end

  // Next-state, SRAM strobes and response generation.
  always_comb begin
    state_d   = state_q;
    rd_bank_d = rd_bank_q;
    ack_d     = 1'b0;
    dat_r_d   = dat_r_q;
    csb_s     = {NUM_BANKS{1'b1}};
    web_s     = 1'b1;
`ifdef CLUSTERV_MEMC_RANGE_ERR_EN
    err_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (req_s && dec_in_range_s) begin
          csb_s     = ~bank_sel_s;
          web_s     = ~t_we;
          rd_bank_d = dec_bank_s;
          if (t_we) begin
            state_d = WR_ACK;
            ack_d   = 1'b1;
          end else begin
            state_d = RD_WAIT;
          end
        end else if (req_s) begin
`ifdef CLUSTERV_MEMC_RANGE_ERR_EN
          state_d = ERR_ACK;
          err_d   = 1'b1;
`else
          state_d = IDLE;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      // SRAM data is valid this cycle; the access completes even if t_cyc dropped.
      RD_WAIT: begin
        dat_r_d = rd_mux_s;
        ack_d   = 1'b1;
        state_d = RD_ACK;
      end
      WR_ACK, RD_ACK, ERR_ACK: begin
        state_d = is_resp_state(state_q) ? IDLE : state_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and response registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rd_bank_q <= {BANK_IDX_W{1'b0}};
      ack_q     <= 1'b0;
      dat_r_q   <= 32'd0;
`ifdef CLUSTERV_MEMC_RANGE_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rd_bank_q <= rd_bank_d;
      ack_q     <= ack_d;
      dat_r_q   <= dat_r_d;
`ifdef CLUSTERV_MEMC_RANGE_ERR_EN
      err_q     <= err_d;
`endif
    end
  end

  assign t_ack      = ack_q;
  assign t_dat_r    = dat_r_q;
`ifdef CLUSTERV_MEMC_RANGE_ERR_EN
  assign t_err      = err_q;
`else
  assign t_err      = 1'b0;
`endif
  assign sram_csb   = csb_s;
  assign sram_web   = web_s;
  assign sram_wmask = t_sel;
  assign sram_addr  = dec_word_s;
  assign sram_din   = t_dat_w;

endmodule

// File: tb/tb_clusterv_mem_ctrl_nbank.sv
// Bench for clusterv_mem_ctrl_nbank: a 4-bank and a 3-bank instance share one Wishbone stimulus,
// checked every cycle against a transaction-timeline model plus directed literal expectations.
module tb_clusterv_mem_ctrl_nbank;

  localparam int AW = 9;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] t_adr = 32'd0;
  logic [31:0] t_dat_w = 32'd0;
  logic        t_cyc = 1'b0;
  logic        t_stb = 1'b0;
  logic        t_we = 1'b0;
  logic [3:0]  t_sel = 4'd0;

  logic [31:0]   dat_r0, dat_r1;
  logic          ack0, ack1, err0, err1;
  logic [3:0]    csb0;
  logic [2:0]    csb1;
  logic          web0, web1;
  logic [3:0]    wm0, wm1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   din0, din1;

  logic [31:0]  dout_v [4];
  logic [127:0] dout0;
  logic [95:0]  dout1;
  assign dout0 = {dout_v[3], dout_v[2], dout_v[1], dout_v[0]};
  assign dout1 = {dout_v[2], dout_v[1], dout_v[0]};

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc_n <= cyc_n + 1;

  clusterv_mem_ctrl_nbank #(.NUM_BANKS(4), .BANK_ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(dat_r0),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel), .t_ack(ack0), .t_err(err0),
    .sram_csb(csb0), .sram_web(web0), .sram_wmask(wm0), .sram_addr(addr0), .sram_din(din0),
    .sram_dout(dout0)
  );

  clusterv_mem_ctrl_nbank #(.NUM_BANKS(3), .BANK_ADDR_W(AW)) dut3 (
    .clock(clock), .reset(reset), .t_adr(t_adr), .t_dat_w(t_dat_w), .t_dat_r(dat_r1),
    .t_cyc(t_cyc), .t_stb(t_stb), .t_we(t_we), .t_sel(t_sel), .t_ack(ack1), .t_err(err1),
    .sram_csb(csb1), .sram_web(web1), .sram_wmask(wm1), .sram_addr(addr1), .sram_din(din1),
    .sram_dout(dout1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bus(input logic cyc, input logic stb, input logic we,
                     input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    @(posedge clock);
    #1;
    t_cyc = cyc; t_stb = stb; t_we = we; t_adr = adr; t_dat_w = dat; t_sel = sel;
  endtask

  // Timeline model: cycle index at which each instance is free, acks, errors and read capture.
  int          free_at   [2] = '{0, 0};
  int          wr_ack_at [2] = '{-1, -1};
  int          rd_ack_at [2] = '{-1, -1};
  int          err_at    [2] = '{-1, -1};
  int          cap_at    [2] = '{-1, -1};
  int          cap_bank  [2] = '{0, 0};
  logic [31:0] cap_val   [2] = '{32'd0, 32'd0};
  logic [31:0] exp_dat   [2] = '{32'd0, 32'd0};

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      int          nb;
      int          bank;
      logic [2:0]  raw;
      logic        acc_ok;
      logic [7:0]  exp_csb, act_csb;
      logic        exp_web, exp_ack, exp_err, act_web, act_ack, act_err;
      logic [31:0] act_dat;
      nb      = (i == 0) ? 4 : 3;
      exp_csb = 8'hFF;
      exp_web = 1'b1;
      if (!reset) begin
        free_at[i] = 0; wr_ack_at[i] = -1; rd_ack_at[i] = -1;
        err_at[i] = -1; cap_at[i] = -1; exp_dat[i] = 32'd0;
      end else begin
        if (cyc_n == cap_at[i]) cap_val[i] = dout_v[cap_bank[i]];
        if (cyc_n == rd_ack_at[i]) exp_dat[i] = cap_val[i];
        if (t_cyc && t_stb && cyc_n >= free_at[i]) begin
          raw    = t_adr[2+AW +: 3];
          acc_ok = 1'b1;
`ifdef CLUSTERV_MEMC_RANGE_ERR_EN
          if (int'(raw) >= nb) acc_ok = 1'b0;
`endif
          if (!acc_ok) begin
            err_at[i]  = cyc_n + 1;
            free_at[i] = cyc_n + 2;
          end else begin
            bank          = int'(raw) % nb;
            exp_csb[bank] = 1'b0;
            exp_web       = ~t_we;
            if (t_we) begin
              wr_ack_at[i] = cyc_n + 1;
              free_at[i]   = cyc_n + 2;
            end else begin
              cap_at[i]    = cyc_n + 1;
              cap_bank[i]  = bank;
              rd_ack_at[i] = cyc_n + 2;
              free_at[i]   = cyc_n + 3;
            end
          end
        end
      end
      exp_ack = (cyc_n == wr_ack_at[i]) || (cyc_n == rd_ack_at[i]);
      exp_err = (cyc_n == err_at[i]);
      act_csb = (i == 0) ? {4'hF, csb0} : {5'h1F, csb1};
      act_web = (i == 0) ? web0 : web1;
      act_ack = (i == 0) ? ack0 : ack1;
      act_err = (i == 0) ? err0 : err1;
      act_dat = (i == 0) ? dat_r0 : dat_r1;
      chk($sformatf("model_csb[%0d]", i), {24'd0, act_csb}, {24'd0, exp_csb});
      chk($sformatf("model_web[%0d]", i), {31'd0, act_web}, {31'd0, exp_web});
      chk($sformatf("model_ack[%0d]", i), {31'd0, act_ack}, {31'd0, exp_ack});
      chk($sformatf("model_err[%0d]", i), {31'd0, act_err}, {31'd0, exp_err});
      chk($sformatf("model_dat_r[%0d]", i), act_dat, exp_dat[i]);
      if (exp_csb != 8'hFF) begin
        chk($sformatf("model_addr[%0d]", i), {23'd0, (i == 0) ? addr0 : addr1}, {23'd0, t_adr[2 +: AW]});
        chk($sformatf("model_wmask[%0d]", i), {28'd0, (i == 0) ? wm0 : wm1}, {28'd0, t_sel});
        chk($sformatf("model_din[%0d]", i), (i == 0) ? din0 : din1, t_dat_w);
      end
    end
  end

  initial begin
    dout_v[0] = 32'h0000_A000;
    dout_v[1] = 32'h1234_5678;
    dout_v[2] = 32'hA5A5_0002;
    dout_v[3] = 32'h3333_0003;

    repeat (2) @(negedge clock);
    chk("rst_ack", {31'd0, ack0}, 32'd0);
    chk("rst_csb", {28'd0, csb0}, 32'h0000_000F);
    chk("rst_dat_r", dat_r0, 32'd0);
    @(posedge clock); #3 reset = 1'b1;

    // Write 0xDEADBEEF to bank 1 word 1.
    bus(1'b1, 1'b1, 1'b1, 32'h0000_0804, 32'hDEAD_BEEF, 4'hF);
    @(negedge clock);
    chk("wr_csb_N", {28'd0, csb0}, 32'h0000_000D);
    chk("wr_addr_N", {23'd0, addr0}, 32'd1);
    chk("wr_web_N", {31'd0, web0}, 32'd0);
    chk("wr_ack_N", {31'd0, ack0}, 32'd0);
    bus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    @(negedge clock);
    chk("wr_ack_N1", {31'd0, ack0}, 32'd1);
    chk("wr_csb_N1", {28'd0, csb0}, 32'h0000_000F);

    // Read bank 1 word 1 with strobe held until ack.
    bus(1'b1, 1'b1, 1'b0, 32'h0000_0804, 32'd0, 4'hF);
    @(negedge clock);
    chk("rd_csb_N", {28'd0, csb0}, 32'h0000_000D);
    chk("rd_web_N", {31'd0, web0}, 32'd1);
    @(negedge clock);
    chk("rd_ack_N1", {31'd0, ack0}, 32'd0);
    chk("rd_csb_N1", {28'd0, csb0}, 32'h0000_000F);
    @(negedge clock);
    chk("rd_ack_N2", {31'd0, ack0}, 32'd1);
    chk("rd_dat_N2", dat_r0, 32'h1234_5678);
    chk("rd_csb_N2", {28'd0, csb0}, 32'h0000_000F);
    bus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);

    // Partial byte write, strobe held through the ack cycle.
    bus(1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, 4'b0100);
    @(negedge clock);
    chk("sel_wmask_N", {28'd0, wm0}, 32'h0000_0004);
    chk("sel_csb_N", {28'd0, csb0}, 32'h0000_000E);
    @(negedge clock);
    chk("sel_ack_N1", {31'd0, ack0}, 32'd1);
    chk("sel_no_2nd_csb", {28'd0, csb0}, 32'h0000_000F);
    bus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    @(negedge clock);
    chk("sel_ack_N2", {31'd0, ack0}, 32'd0);

    // Bank 3: populated on the 4-bank instance, beyond range on the 3-bank one.
    bus(1'b1, 1'b1, 1'b1, 32'h0000_1800, 32'h0BAD_F00D, 4'hF);
    @(negedge clock);
    chk("b3_csb4_N", {28'd0, csb0}, 32'h0000_0007);
`ifdef CLUSTERV_MEMC_RANGE_ERR_EN
    chk("b3_csb3_N", {29'd0, csb1}, 32'h0000_0007);
`else
    chk("b3_csb3_N", {29'd0, csb1}, 32'h0000_0006);
`endif
    bus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    @(negedge clock);
    chk("b3_ack4_N1", {31'd0, ack0}, 32'd1);
`ifdef CLUSTERV_MEMC_RANGE_ERR_EN
    chk("b3_err3_N1", {31'd0, err1}, 32'd1);
    chk("b3_ack3_N1", {31'd0, ack1}, 32'd0);
`else
    chk("b3_err3_N1", {31'd0, err1}, 32'd0);
    chk("b3_ack3_N1", {31'd0, ack1}, 32'd1);
`endif

    // Write with no byte selects still completes.
    bus(1'b1, 1'b1, 1'b1, 32'h0000_1004, 32'h5555_AAAA, 4'h0);
    @(negedge clock);
    chk("sel0_wmask_N", {28'd0, wm0}, 32'd0);
    chk("sel0_csb_N", {28'd0, csb0}, 32'h0000_000B);
    bus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    @(negedge clock);
    chk("sel0_ack_N1", {31'd0, ack0}, 32'd1);

    // Master abandons the read in RD_WAIT; the ack still arrives.
    bus(1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'd0, 4'hF);
    bus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    @(negedge clock);
    chk("drop_ack_N1", {31'd0, ack0}, 32'd0);
    @(negedge clock);
    chk("drop_ack_N2", {31'd0, ack0}, 32'd1);
    chk("drop_dat_N2", dat_r0, 32'hA5A5_0002);

    // Reset while in RD_WAIT.
    bus(1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'd0, 4'hF);
    @(posedge clock);
    #2 reset = 1'b0; t_cyc = 1'b0; t_stb = 1'b0;
    #1;
    chk("rst_rw_csb", {28'd0, csb0}, 32'h0000_000F);
    chk("rst_rw_ack", {31'd0, ack0}, 32'd0);
    chk("rst_rw_dat", dat_r0, 32'd0);
    @(posedge clock); #3 reset = 1'b1;
    @(negedge clock);
    chk("rst_rel_ack0", {31'd0, ack0}, 32'd0);
    @(negedge clock);
    chk("rst_rel_ack1", {31'd0, ack0}, 32'd0);
    bus(1'b1, 1'b1, 1'b0, 32'h0000_0804, 32'd0, 4'hF);
    @(negedge clock);
    chk("rst_rd_csb_N", {28'd0, csb0}, 32'h0000_000D);
    @(negedge clock);
    @(negedge clock);
    chk("rst_rd_ack_N2", {31'd0, ack0}, 32'd1);
    chk("rst_rd_dat_N2", dat_r0, 32'h1234_5678);
    bus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);

    // Back-to-back write then read, strobe never dropped.
    bus(1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'h1122_3344, 4'hF);
    @(negedge clock);
    chk("b2b_wr_csb_N", {28'd0, csb0}, 32'h0000_000E);
    bus(1'b1, 1'b1, 1'b0, 32'h0000_1804, 32'd0, 4'hF);
    @(negedge clock);
    chk("b2b_ack_N1", {31'd0, ack0}, 32'd1);
    chk("b2b_csb_N1", {28'd0, csb0}, 32'h0000_000F);
    @(negedge clock);
    chk("b2b_rd_csb_N2", {28'd0, csb0}, 32'h0000_0007);
    chk("b2b_ack_N2", {31'd0, ack0}, 32'd0);
    @(negedge clock);
    chk("b2b_ack_N3", {31'd0, ack0}, 32'd0);
    @(negedge clock);
    chk("b2b_ack_N4", {31'd0, ack0}, 32'd1);
    chk("b2b_dat_N4", dat_r0, 32'h3333_0003);
    bus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
